vga_timing_gen: RTL and testbench

Timing generator for the 640x480@60 VGA path. It divides the board clock into a pixel-rate enable and runs free horizontal and vertical counters. It drives hCount, vCount and bright to the game/pixel logic, and hSync and vSync to the connector. It also emits a once-per-frame strobe that the game logic uses as its slow update enable.

---
 rtl/vga_timing_gen.sv | 96 +++++++++
 tb/tb_vga_timing_gen.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - 640x480@60 VGA timing generator with pixel enable and frame strobe
module vga_timing_gen #(
  parameter int CLK_DIV = 4,
  parameter int H_TOTAL = 800,
  parameter int H_SYNC  = 96,
  parameter int H_START = 144,
  parameter int H_END   = 784,
  parameter int V_TOTAL = 525,
  parameter int V_SYNC  = 2,
  parameter int V_START = 35,
  parameter int V_END   = 515
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] hCount,
  output logic [9:0] vCount,
  output logic       bright,
  output logic       hSync,
  output logic       vSync,
  output logic       pix_en,
  output logic       frame_tick
);

  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SYNC_W = 10'(H_SYNC);
  localparam logic [9:0] H_BEG_W  = 10'(H_START);
  localparam logic [9:0] H_END_W  = 10'(H_END);
  localparam logic [9:0] V_SYNC_W = 10'(V_SYNC);
  localparam logic [9:0] V_BEG_W  = 10'(V_START);
  localparam logic [9:0] V_END_W  = 10'(V_END);

  logic [3:0] div;
  logic       adv;
  logic       h_wrap;
  logic       v_wrap;
  logic [9:0] h_next;
  logic [9:0] v_next;
  logic       bright_next;

  // Next-count values; sync and window flags are derived from these so they
  // land in the same register update as the counts and never lag them.
  always_comb begin
    adv         = (div == DIV_LAST);
    h_wrap      = (hCount == H_LAST);
    v_wrap      = (vCount == V_LAST);
    h_next      = h_wrap ? 10'd0 : hCount + 10'd1;
    v_next      = vCount;
    if (h_wrap) begin
      v_next = v_wrap ? 10'd0 : vCount + 10'd1;
    end
    bright_next = (h_next >= H_BEG_W) && (h_next < H_END_W) &&
                  (v_next >= V_BEG_W) && (v_next < V_END_W);
  end

  // Board-clock divider; the edge where it sits at its last value is the advance edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div <= 4'd0;
    end else if (adv) begin
      div <= 4'd0;
    end else begin
      div <= div + 4'd1;
    end
  end

  // Counters and timing flags move only on advance edges and hold otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hCount <= 10'd0;
      vCount <= 10'd0;
      bright <= 1'b0;
      hSync  <= 1'b0;
      vSync  <= 1'b0;
    end else if (adv) begin
      hCount <= h_next;
      vCount <= v_next;
      bright <= bright_next;
      hSync  <= (h_next >= H_SYNC_W);
      vSync  <= (v_next >= V_SYNC_W);
    end
  end

  // One-cycle strobes marking the cycle in which new counts first appear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix_en     <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      pix_en     <= adv;
      frame_tick <= adv && h_wrap && v_wrap;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed bench for vga_timing_gen
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [9:0] a_h, a_v, b_h, b_v, c_h, c_v;
  logic a_br, a_hs, a_vs, a_pix, a_ft;
  logic b_br, b_hs, b_vs, b_pix, b_ft;
  logic c_br, c_hs, c_vs, c_pix, c_ft;

  int errors = 0;
  int checks = 0;
  int a_ft_cnt = 0;
  int lows;
  int seq_err;
  int b_ft_cnt;
  int b_pix_low;
  int c_ft_cnt;

  always #5 clk = ~clk;

  // default geometry, 4 board clocks per pixel
  vga_timing_gen u_a (
    .clk(clk), .rst(rst), .hCount(a_h), .vCount(a_v), .bright(a_br),
    .hSync(a_hs), .vSync(a_vs), .pix_en(a_pix), .frame_tick(a_ft)
  );

  // small geometry, pixel every clock
  vga_timing_gen #(
    .CLK_DIV(1), .H_TOTAL(12), .H_SYNC(2), .H_START(3), .H_END(10),
    .V_TOTAL(8), .V_SYNC(1), .V_START(2), .V_END(6)
  ) u_b (
    .clk(clk), .rst(rst), .hCount(b_h), .vCount(b_v), .bright(b_br),
    .hSync(b_hs), .vSync(b_vs), .pix_en(b_pix), .frame_tick(b_ft)
  );

  // small geometry, pixel every third clock
  vga_timing_gen #(
    .CLK_DIV(3), .H_TOTAL(12), .H_SYNC(2), .H_START(3), .H_END(10),
    .V_TOTAL(8), .V_SYNC(1), .V_START(2), .V_END(6)
  ) u_c (
    .clk(clk), .rst(rst), .hCount(c_h), .vCount(c_v), .bright(c_br),
    .hSync(c_hs), .vSync(c_vs), .pix_en(c_pix), .frame_tick(c_ft)
  );

  always @(negedge clk) if (a_ft === 1'b1) a_ft_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_a_reset(input string tag);
    check({tag, "_h"}, a_h, 0);
    check({tag, "_v"}, a_v, 0);
    check({tag, "_bright"}, a_br, 0);
    check({tag, "_hs"}, a_hs, 0);
    check({tag, "_vs"}, a_vs, 0);
    check({tag, "_pix"}, a_pix, 0);
    check({tag, "_ft"}, a_ft, 0);
  endtask

  task automatic check_a_startup(input string tag);
    for (int e = 1; e <= 3; e++) begin
      tick(1);
      check({tag, "_pre_h"}, a_h, 0);
      check({tag, "_pre_pix"}, a_pix, 0);
    end
    tick(1);
    check({tag, "_e4_h"}, a_h, 1);
    check({tag, "_e4_v"}, a_v, 0);
    check({tag, "_e4_pix"}, a_pix, 1);
    check({tag, "_e4_ft"}, a_ft, 0);
    check({tag, "_e4_hs"}, a_hs, 0);
    tick(1);
    check({tag, "_e5_pix"}, a_pix, 0);
    check({tag, "_e5_h"}, a_h, 1);
  endtask

  initial begin
    // reset before any clock edge has occurred
    #1 rst = 1'b0;
    #1;
    check_a_reset("rst0");
    check("rst0_b_h", b_h, 0);
    check("rst0_b_pix", b_pix, 0);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    check_a_startup("start");

    // walk line 0 pixel by pixel (now at edge 5, h=1)
    tick(3);
    lows = 0;
    seq_err = 0;
    for (int i = 2; i < 800; i++) begin
      if (a_h !== 10'(i)) seq_err++;
      if (a_hs === 1'b0) lows++;
      if (i == 95) check("hsync_h95", a_hs, 0);
      if (i == 96) check("hsync_h96", a_hs, 1);
      if (i < 799) tick(4);
    end
    check("hsync_low_px", lows, 94);
    check("h_seq", seq_err, 0);
    check("v_line0", a_v, 0);

    tick(4);
    check("wrap_h", a_h, 0);
    check("wrap_v", a_v, 1);
    check("wrap_pix", a_pix, 1);
    check("wrap_hs", a_hs, 0);
    check("wrap_vs", a_vs, 0);
    check("wrap_ft", a_ft, 0);

    tick(4 * 799);
    check("l1_end_h", a_h, 799);
    check("l1_end_vs", a_vs, 0);
    check("l1_end_hs", a_hs, 1);
    check("l1_bright", a_br, 0);
    tick(4);
    check("l2_v", a_v, 2);
    check("l2_vs", a_vs, 1);

    // asynchronous reset mid-line, mid-divider
    tick(4 * 500);
    check("mid_h", a_h, 500);
    check("mid_hs", a_hs, 1);
    tick(2);
    check("mid_div_pix", a_pix, 0);
    #2 rst = 1'b0;
    #1;
    check_a_reset("rst_mid");
    repeat (10) @(negedge clk);
    rst = 1'b1;
    check_a_startup("recov");
    check("a_no_ft", a_ft_cnt, 0);

    // fresh reset, then run the small-geometry instances over full frames
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    b_ft_cnt = 0;
    b_pix_low = 0;
    c_ft_cnt = 0;
    for (int e = 1; e <= 600; e++) begin
      tick(1);
      if (e <= 200) begin
        if (b_pix !== 1'b1) b_pix_low++;
        if (b_ft === 1'b1) b_ft_cnt++;
      end
      if (c_ft === 1'b1) c_ft_cnt++;
      case (e)
        1: begin
          check("b_e1_h", b_h, 1);
          check("b_e1_v", b_v, 0);
          check("b_e1_hs", b_hs, 0);
        end
        2:  check("b_e2_hs", b_hs, 1);
        11: check("b_vs_v0", b_vs, 0);
        12: begin
          check("b_wrap_h", b_h, 0);
          check("b_wrap_v", b_v, 1);
          check("b_vs_v1", b_vs, 1);
        end
        15: check("b_br_3_1", b_br, 0);
        26: check("b_br_2_2", b_br, 0);
        27: check("b_br_3_2", b_br, 1);
        69: begin
          check("b_br_9_5", b_br, 1);
          check("b_h69", b_h, 9);
        end
        70: check("b_br_10_5", b_br, 0);
        75: check("b_br_3_6", b_br, 0);
        95: begin
          check("b_pre_ft", b_ft, 0);
          check("b_pre_h", b_h, 11);
          check("b_pre_v", b_v, 7);
        end
        96: begin
          check("b_ft", b_ft, 1);
          check("b_ft_h", b_h, 0);
          check("b_ft_v", b_v, 0);
        end
        97:  check("b_post_ft", b_ft, 0);
        287: check("c_pre_ft", c_ft, 0);
        288: begin
          check("c_ft", c_ft, 1);
          check("c_ft_pix", c_pix, 1);
          check("c_ft_h", c_h, 0);
          check("c_ft_v", c_v, 0);
        end
        289: begin
          check("c_post_ft", c_ft, 0);
          check("c_post_pix", c_pix, 0);
        end
        576: check("c_ft2", c_ft, 1);
        default: ;
      endcase
    end
    check("b_ft_count", b_ft_cnt, 2);
    check("b_pix_low", b_pix_low, 0);
    check("c_ft_count", c_ft_cnt, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
